// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// start/busy/done handshake. Result is registered and held until the next completion.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one multiply/divide iteration per cycle (single pass for special cases)
  // FIX   | sign correction and result select
  // DONE  | result valid for one cycle; start accepted here as in IDLE
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod;
  logic              neg;
  logic              special;
  logic [XLEN-1:0]   spec_res;
  logic [CNT_W-1:0]  cnt;

  logic              a_signed, b_signed, a_neg, b_neg, sign_in;
  logic              div_zero, div_ovf, accept, last_iter;
  logic [XLEN-1:0]   a_mag, b_mag, spec_in, fix_val;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_nx, mul_v;

  // Signed: MUL/MULH/DIV/REM both; MULHSU only A; MULHU/DIVU/REMU neither.
  assign a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign b_signed = op[2] ? ~op[0] : ~op[1];
  assign a_neg    = a_signed & A[XLEN-1];
  assign b_neg    = b_signed & B[XLEN-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;
  assign sign_in  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = op[2] & (B == '0);
  assign div_ovf  = op[2] & ~op[0] & (A == MIN_NEG) & (B == '1);
  assign spec_in  = div_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);

  assign accept    = start & ((state == S_IDLE) | (state == S_DONE));
  assign last_iter = (cnt == CNT_W'(1));

  // Multiply: upper half accumulates B, whole register shifts right.
  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
  assign rem_sh  = prod[2*XLEN-1:XLEN-1];
  assign diff    = rem_sh - {1'b0, mag_b};
  assign prod_nx = op_r[2] ?
                   {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]), prod[XLEN-2:0], ~diff[XLEN]} :
                   {mul_sum, prod[XLEN-1:1]};

  assign mul_v = neg ? -prod : prod;

  always_comb begin
    fix_val = '0;
    if (special)
      fix_val = spec_res;
    else if (!op_r[2])
      fix_val = (op_r[1:0] == 2'b00) ? mul_v[XLEN-1:0] : mul_v[2*XLEN-1:XLEN];
    else if (op_r[1])
      fix_val = neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    else
      fix_val = neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_CALC;
      S_CALC:  if (special || last_iter) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = accept ? S_CALC : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r     <= '0;
      mag_b    <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      special  <= 1'b0;
      spec_res <= '0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        op_r     <= op;
        mag_b    <= b_mag;
        prod     <= {{XLEN{1'b0}}, a_mag};
        neg      <= sign_in;
        special  <= div_zero | div_ovf;
        spec_res <= spec_in;
        cnt      <= CNT_W'(XLEN);
      end else if (state == S_CALC && !special) begin
        prod <= prod_nx;
        cnt  <= cnt - CNT_W'(1);
      end
      if (state == S_FIX) result <= fix_val;
    end
  end

  assign busy = (state == S_CALC) | (state == S_FIX);
  assign done = (state == S_DONE);

endmodule
